// File: rtl/t_stream_pkg.sv
// t_stream_pkg: shared constants for the 1101 stream detector.
//   STATE_W  - width of the FSM state code
//   state_t  - state codes ST_A..ST_E (5..7 unused/illegal)
//   PATTERN  - detected bit pattern, oldest bit first (reference only)
package t_stream_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [3:0] PATTERN = 4'b1101;

  typedef enum logic [STATE_W-1:0] {
    ST_A = 3'd0,  // nothing matched
    ST_B = 3'd1,  // "1"
    ST_C = 3'd2,  // "11"
    ST_D = 3'd3,  // "110"
    ST_E = 3'd4   // "1101" matched
  } state_t;

endpackage

// File: rtl/t_stream_detector_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
//   Clk            - clock, rising edge
//   asynch_reset_n - asynchronous active-low reset, value -> 0
//   inc            - count up by one (held at all-ones once reached)
//   clr            - synchronous clear, takes priority over inc
//   value          - current count
module sat_counter #(
  parameter int unsigned COUNT_W = 8
) (
  input  logic               Clk,
  input  logic               asynch_reset_n,
  input  logic               inc,
  input  logic               clr,
  output logic [COUNT_W-1:0] value
);

  always_ff @(posedge Clk or negedge asynch_reset_n) begin
    if (!asynch_reset_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc && (value != '1)) begin
      value <= value + COUNT_W'(1);
    end
  end

endmodule

// File: rtl/t_stream_detector.sv
// t_stream_detector: Moore FSM detecting 1101 (with overlap) on the serial
// bit T, plus a saturating count of detections.
//   Clk            - clock, rising edge
//   asynch_reset_n - asynchronous active-low reset
//   T              - serial data bit
//   En             - sample enable; T consumed only when En=1
//   Clear          - synchronous clear of Count (FSM unaffected)
//   Match          - high while the FSM is in state E
//   Count          - saturating number of detections
//   State          - current FSM state code, for debug display
module t_stream_detector
  import t_stream_pkg::*;
#(
  parameter int unsigned COUNT_W = 8
) (
  input  logic               Clk,
  input  logic               asynch_reset_n,
  input  logic               T,
  input  logic               En,
  input  logic               Clear,
  output logic               Match,
  output logic [COUNT_W-1:0] Count,
  output logic [STATE_W-1:0] State
);

  // Plain vector rather than state_t so illegal codes 5..7 are representable
  // and recover through the default branch.
  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] next_state;
  logic               inc;

  always_comb begin
    next_state = state_q;
    case (state_q)
      ST_A:    if (En) next_state = T ? ST_B : ST_A;
      ST_B:    if (En) next_state = T ? ST_C : ST_A;
      ST_C:    if (En) next_state = T ? ST_C : ST_D;
      ST_D:    if (En) next_state = T ? ST_E : ST_A;
      ST_E:    if (En) next_state = T ? ST_C : ST_A;
      default: next_state = ST_A;  // illegal code recovers regardless of En
    endcase
  end

  always_ff @(posedge Clk or negedge asynch_reset_n) begin
    if (!asynch_reset_n) begin
      state_q <= ST_A;
    end else begin
      state_q <= next_state;
    end
  end

  // Counting on entry into E keeps Count in step with Match.
  assign inc = En && (next_state == ST_E);

  sat_counter #(
    .COUNT_W(COUNT_W)
  ) u_count (
    .Clk           (Clk),
    .asynch_reset_n(asynch_reset_n),
    .inc           (inc),
    .clr           (Clear),
    .value         (Count)
  );

  assign State = state_q;
  assign Match = (state_q == ST_E);

endmodule

// File: tb/tb_t_stream_detector.sv
// tb_t_stream_detector: directed bench for t_stream_detector. Two instances
// (COUNT_W=8 and COUNT_W=2) share stimulus; a history-based model predicts
// state, match and counts and is compared every cycle.
module tb_t_stream_detector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       t;
  logic       en;
  logic       clr;
  logic [2:0] st8, st2;
  logic       m8, m2;
  logic [7:0] c8;
  logic [1:0] c2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  t_stream_detector #(.COUNT_W(8)) dut8 (
    .Clk(clk), .asynch_reset_n(rst_n), .T(t), .En(en), .Clear(clr),
    .Match(m8), .Count(c8), .State(st8)
  );

  t_stream_detector #(.COUNT_W(2)) dut2 (
    .Clk(clk), .asynch_reset_n(rst_n), .T(t), .En(en), .Clear(clr),
    .Match(m2), .Count(c2), .State(st2)
  );

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: the expected state is the longest suffix of the sampled bits that
  // is a prefix of 1101.
  logic [3:0] h = 4'b0;
  int         n = 0;
  bit         ill = 1'b0;
  int         mc8 = 0;
  int         mc2 = 0;
  bit         hit;

  function automatic int exp_state();
    if (ill) return 6;
    if (n >= 4 && h == 4'b1101) return 4;
    if (n >= 3 && h[2:0] == 3'b110) return 3;
    if (n >= 2 && h[1:0] == 2'b11) return 2;
    if (n >= 1 && h[0]) return 1;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h = 4'b0; n = 0; ill = 1'b0; mc8 = 0; mc2 = 0;
    end else begin
      hit = 1'b0;
      if (ill) begin
        ill = 1'b0; h = 4'b0; n = 0;
      end else if (en) begin
        h = {h[2:0], t};
        if (n < 4) n++;
        hit = (exp_state() == 4);
      end
      if (clr) begin
        mc8 = 0; mc2 = 0;
      end else if (hit) begin
        if (mc8 < 255) mc8++;
        if (mc2 < 3) mc2++;
      end
    end
  end

  always @(negedge clk) begin
    chk("state8", int'(st8), exp_state());
    chk("match8", int'(m8), int'(exp_state() == 4));
    chk("count8", int'(c8), mc8);
    chk("state2", int'(st2), exp_state());
    chk("match2", int'(m2), int'(exp_state() == 4));
    chk("count2", int'(c2), mc2);
  end

  task automatic step(input logic tv, input logic ev, input logic cv);
    t = tv; en = ev; clr = cv;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_state", int'(st8), 0);
    chk("rst_count", int'(c8), 0);
    chk("rst_match", int'(m8), 0);
    chk("rst_count2", int'(c2), 0);
    rst_n = 1'b1;
  endtask

  task automatic force_illegal();
    force dut8.state_q = 3'd6;
    force dut2.state_q = 3'd6;
    ill = 1'b1;
    #1;
    release dut8.state_q;
    release dut2.state_q;
    #1;
    chk("ill_state", int'(st8), 6);
    chk("ill_match", int'(m8), 0);
  endtask

  logic [6:0] ov_bits = 7'b1101101;
  int         ov_st[7] = '{1, 2, 3, 4, 2, 3, 4};
  int         ov_m[7]  = '{0, 0, 0, 1, 0, 0, 1};
  int         ov_c[7]  = '{0, 0, 0, 1, 1, 1, 2};
  logic [7:0] nm_bits = 8'b11100101;
  int         nm_st[8] = '{1, 2, 2, 3, 0, 1, 0, 1};
  logic [3:0] pat = 4'b1101;
  int         sat_c[4] = '{1, 2, 3, 3};

  initial begin
    t = 1'b0; en = 1'b0; clr = 1'b0; rst_n = 1'b1;
    #1 do_reset();
    rst_n = 1'b0;
    #10 rst_n = 1'b1;

    // Overlapping stream 1101101
    for (int i = 0; i < 7; i++) begin
      step(ov_bits[6-i], 1'b1, 1'b0);
      chk("ov_state", int'(st8), ov_st[i]);
      chk("ov_match", int'(m8), ov_m[i]);
      chk("ov_count", int'(c8), ov_c[i]);
    end

    // Near-misses 11100101
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(nm_bits[7-i], 1'b1, 1'b0);
      chk("nm_state", int'(st8), nm_st[i]);
      chk("nm_match", int'(m8), 0);
    end
    chk("nm_count", int'(c8), 0);

    // Enable gating
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(logic'(i % 2 == 0), 1'b0, 1'b0);
      chk("gate_hold", int'(st8), 3);
    end
    step(1'b1, 1'b1, 1'b0);
    chk("gate_match", int'(m8), 1);
    chk("gate_count", int'(c8), 1);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 1'b0);
      chk("e_hold_match", int'(m8), 1);
      chk("e_hold_count", int'(c8), 1);
    end

    // Illegal state recovery with En=0 then En=1
    force_illegal();
    step(1'b1, 1'b0, 1'b0);
    chk("ill_rec_en0", int'(st8), 0);
    chk("ill_cnt_en0", int'(c8), 1);
    force_illegal();
    step(1'b1, 1'b1, 1'b0);
    chk("ill_rec_en1", int'(st8), 0);
    chk("ill_cnt_en1", int'(c8), 1);
    chk("ill_match_en1", int'(m8), 0);

    // Saturation on the 2-bit counter, then Clear against a completion
    do_reset();
    for (int r = 0; r < 4; r++) begin
      for (int b = 0; b < 4; b++) step(pat[3-b], 1'b1, 1'b0);
      chk("sat_count2", int'(c2), sat_c[r]);
      chk("sat_match", int'(m2), 1);
    end
    chk("sat_count8", int'(c8), 4);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("clr_count2", int'(c2), 0);
    chk("clr_count8", int'(c8), 0);
    chk("clr_match", int'(m2), 1);

    // Asynchronous reset mid-stream discards the partial match
    for (int b = 0; b < 4; b++) step(pat[3-b], 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("pre_rst_state", int'(st8), 3);
    chk("pre_rst_count", int'(c8), 1);
    #1 do_reset();
    step(1'b1, 1'b1, 1'b0);
    chk("post_rst_state", int'(st8), 1);
    chk("post_rst_match", int'(m8), 0);
    chk("post_rst_count", int'(c8), 0);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/t_stream_detector.md
# t_stream_detector

Downstream consumer of the part_3 select stage: samples the serial bit T that part_3 produces and detects the pattern 1101, with overlap, using a Moore FSM. It raises a match flag and keeps a saturating count of detected patterns for the lab display/LED stage. It adds real sequential behaviour (FSM plus counter) behind the combinational select path.

## Interface
Parameters:
- COUNT_W, default 8: width of the match counter.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- asynch_reset_n  input  1  asynchronous, active-low reset; one clock domain only.
- T  input  1  serial data bit from part_3.
- En  input  1  sample enable; T is consumed only on edges where En=1.
- Clear  input  1  synchronous clear of Count; does not affect the FSM.
- Match  output  1  high while the FSM is in state E (pattern just completed).
- Count  output  COUNT_W  number of pattern detections, saturating.
- State  output  3  current FSM state, for debug/LED display.

## Operation
- States and encoding: A=0 (nothing matched), B=1 ("1"), C=2 ("11"), D=3 ("110"), E=4 ("1101" matched). Codes 5–7 are illegal.
- Transitions on Clk rising edge when En=1, given T:
  - A: 1→B, 0→A
  - B: 1→C, 0→A
  - C: 1→C, 0→D
  - D: 1→E, 0→A
  - E: 1→C (overlap on "11"), 0→A
- Illegal state codes go to A on the next edge, regardless of En.
- En=0: state holds and T is ignored.
- Match = (State==E). This is a Moore output with no combinational path from T.
- Count increments by 1 on every edge where next state is E and En=1, i.e. once per transition into E.
- Count saturates at 2^COUNT_W−1 and never wraps.
- Clear=1: Count←0 on the next edge. Clear wins over a simultaneous increment. The FSM still advances normally in that cycle.
- Reset (asynch_reset_n=0) acts immediately, without waiting for Clk: State=A, Match=0, Count=0. This applies mid-sequence as well, and any partial match is discarded.
- Release of reset: the first sampling edge is the first Clk rising edge with asynch_reset_n=1.

## Timing
- Latency: Match and the incremented Count both become visible after the same edge that samples the 4th bit of the pattern. Neither has an extra pipeline stage.
- Match stays high for exactly one cycle per detection while En=1. With En=0 in E it stays high until the next enabled edge.
- Overlapping stream 1101101: matches occur after the 4th and the 7th sampled bit, so Count=2.
- Outputs are registered (State, Count) or decoded from State only (Match). Input setup is relative to the Clk rising edge.

## Structure
- Shared package t_stream_pkg holds:
  - state localparams ST_A..ST_E
  - STATE_W=3
  - PATTERN=4'b1101, documentation constant only
- One sub-module, sat_counter, parameterised by COUNT_W:
  - inputs: inc, clr, Clk, asynch_reset_n
  - output: value
  - clr priority over inc; saturates at all-ones.
- Top level contains the FSM: next-state logic, state register and Match decode.

## Test plan
- Reset mid-stream: feed 1,1,0, then pulse asynch_reset_n low between edges → State=0, Count=0 immediately (before the next Clk). Then feed 1 → State=1, and no match.
- Overlap: En=1, feed T=1,1,0,1,1,0,1 → Match high after bits 4 and 7 only, Count=2, State sequence 1,2,3,4,2,3,4.
- Near-misses: feed 1,1,1,0,0,1,0,1 → State 1,2,2,3,0,1,0,1; Match never high, Count=0.
- Enable gating: feed 1,1,0 with En=1, then hold En=0 for 5 cycles toggling T, then En=1 with T=1 → Match after that edge, Count=1.
- Saturation and clear: COUNT_W=2, feed 1101 four times back-to-back non-overlapping → Count 1,2,3,3. Then assert Clear in the same cycle as a 5th completion → Count=0, Match=1.
- Illegal state: force State=6 → next edge State=0 with En=0 or En=1; Count unchanged.
